// File: rtl/tb_status_pkg.sv
// Shared types and constants for the TB status controller.
package tb_status_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } tb_status_e;

    // Exit value recorded when a channel fails through tests_failed_i.
    localparam logic [31:0] TB_EXIT_FAIL_CODE = 32'h1;

    // Verdict states are the sticky terminal states.
    function automatic logic is_done_state(input tb_status_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/tb_chan_status_latch.sv
// Per-channel report latch: remembers the first report of a hart and
// classifies it as pass or fail, keeping the failing exit value.
module tb_chan_status_latch
    import tb_status_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic        passed_i,
    input  logic        failed_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        report_o,
    output logic        new_fail_o,
    output logic        finished_o,
    output logic        failed_o,
    output logic [31:0] value_o
);

    logic        finished_q, finished_d;
    logic        failed_q, failed_d;
    logic [31:0] value_q, value_d;

    // First-report detection and classification; failed > exit > passed.
    always_comb begin
        report_o   = en_i && !finished_q && (passed_i || failed_i || exit_valid_i);
        new_fail_o = report_o && (failed_i || (exit_valid_i && (exit_value_i != '0)));
        finished_d = finished_q;
        failed_d   = failed_q;
        value_d    = value_q;
        if (clear_i) begin
            finished_d = 1'b0;
            failed_d   = 1'b0;
            value_d    = '0;
        end else if (report_o) begin
            finished_d = 1'b1;
            failed_d   = new_fail_o;
            if (failed_i)        value_d = TB_EXIT_FAIL_CODE;
            else if (new_fail_o) value_d = exit_value_i;
            else                 value_d = '0;
        end
    end

    // Latch state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            finished_q <= 1'b0;
            failed_q   <= 1'b0;
            value_q    <= '0;
        end else begin
            finished_q <= finished_d;
            failed_q   <= failed_d;
            value_q    <= value_d;
        end
    end

    assign finished_o = finished_q;
    assign failed_o   = failed_q;
    assign value_o    = value_q;

endmodule

// File: rtl/tb_test_status_ctrl.sv
// Core reset sequencer, cycle watchdog and multi-hart verdict aggregator.
module tb_test_status_ctrl
    import tb_status_pkg::*;
#(
    parameter int NUM_CHANNELS      = 1,
    parameter int CYCLE_W           = 32,
    parameter int RESET_WAIT_CYCLES = 4,
    parameter int FAIL_FAST         = 1
)(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [CYCLE_W-1:0]           max_cycles_i,
    input  logic                         reset_req_i,
    input  logic [NUM_CHANNELS-1:0]      tests_passed_i,
    input  logic [NUM_CHANNELS-1:0]      tests_failed_i,
    input  logic [NUM_CHANNELS-1:0]      exit_valid_i,
    input  logic [NUM_CHANNELS*32-1:0]   exit_value_i,
    output logic                         core_rst_no,
    output tb_status_e                   state_o,
    output logic [CYCLE_W-1:0]           cycle_cnt_o,
    output logic [NUM_CHANNELS-1:0]      finished_o,
    output logic                         done_o,
    output logic                         pass_o,
    output logic                         timeout_o,
    output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] fail_chan_o,
    output logic [31:0]                  fail_value_o
);

    localparam int FCW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int HW  = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_WAIT_CYCLES - 1);

    tb_status_e         state_q, state_d;
    logic               core_rst_q, core_rst_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic               fail_seen_q, fail_seen_d;
    logic [FCW-1:0]     fail_chan_q, fail_chan_d;

    logic [NUM_CHANNELS-1:0]       report, new_fail, finished, failed;
    logic [NUM_CHANNELS-1:0][31:0] value;
    logic [NUM_CHANNELS-1:0]       fin_nxt, fail_nxt;
    logic                          chan_en;
    logic [FCW-1:0]                first_fail;

    // Channels only listen while running; a re-reset request wipes them.
    assign chan_en = (state_q == ST_RUN) && !reset_req_i;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        tb_chan_status_latch u_latch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .clear_i      (reset_req_i),
            .en_i         (chan_en),
            .passed_i     (tests_passed_i[c]),
            .failed_i     (tests_failed_i[c]),
            .exit_valid_i (exit_valid_i[c]),
            .exit_value_i (exit_value_i[32*c +: 32]),
            .report_o     (report[c]),
            .new_fail_o   (new_fail[c]),
            .finished_o   (finished[c]),
            .failed_o     (failed[c]),
            .value_o      (value[c])
        );
    end

    // Exits look at this cycle's reports too, so a report ends the run
    // on the same edge it is latched (one-cycle report-to-done).
    assign fin_nxt  = finished | report;
    assign fail_nxt = failed | new_fail;

    // Lowest-index channel among those newly failing this cycle.
    always_comb begin
        first_fail = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (new_fail[c]) first_fail = FCW'(c);
        end
    end

    // Next-state, counter and fail-capture logic.
    always_comb begin
        state_d     = state_q;
        core_rst_d  = core_rst_q;
        hold_d      = hold_q;
        cycle_d     = cycle_q;
        fail_seen_d = fail_seen_q;
        fail_chan_d = fail_chan_q;
        if (reset_req_i) begin
            state_d     = ST_RESET;
            core_rst_d  = 1'b0;
            hold_d      = '0;
            fail_seen_d = 1'b0;
            fail_chan_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d    = ST_RUN;
                        core_rst_d = 1'b1;
                        cycle_d    = '0;
                        hold_d     = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if ((|new_fail) && !fail_seen_q) begin
                        fail_seen_d = 1'b1;
                        fail_chan_d = first_fail;
                    end
                    // Counter only advances while staying in RUN, so the
                    // frozen value is the cycle the run ended on.
                    if ((FAIL_FAST != 0) && (|fail_nxt)) begin
                        state_d = ST_FAIL;
                    end else if (&fin_nxt) begin
                        state_d = (|fail_nxt) ? ST_FAIL : ST_PASS;
                    end else if ((max_cycles_i != '0) && (cycle_q >= max_cycles_i)) begin
                        state_d = ST_TIMEOUT;
                    end else if (cycle_q != '1) begin
                        cycle_d = cycle_q + 1'b1;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: ;
                default: begin
                    state_d    = ST_RESET;
                    core_rst_d = 1'b0;
                    hold_d     = '0;
                end
            endcase
        end
    end

    // Controller state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RESET;
            core_rst_q  <= 1'b0;
            hold_q      <= '0;
            cycle_q     <= '0;
            fail_seen_q <= 1'b0;
            fail_chan_q <= '0;
        end else begin
            state_q     <= state_d;
            core_rst_q  <= core_rst_d;
            hold_q      <= hold_d;
            cycle_q     <= cycle_d;
            fail_seen_q <= fail_seen_d;
            fail_chan_q <= fail_chan_d;
        end
    end

    // The captured channel's latch holds its failing value until cleared.
    always_comb begin
        fail_value_o = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (fail_seen_q && (fail_chan_q == FCW'(c))) fail_value_o = value[c];
        end
    end

    assign core_rst_no = core_rst_q;
    assign state_o     = state_q;
    assign cycle_cnt_o = cycle_q;
    assign finished_o  = finished;
    assign done_o      = is_done_state(state_q);
    assign pass_o      = (state_q == ST_PASS);
    assign timeout_o   = (state_q == ST_TIMEOUT);
    assign fail_chan_o = fail_chan_q;

endmodule

// File: tb/tb_tb_test_status_ctrl.sv
// Scoreboard bench: two controllers (FAIL_FAST 0 and 1) share stimulus; a
// run-level reference model predicts each verdict, a monitor checks on done_o.
module tb_tb_test_status_ctrl;
    import tb_status_pkg::*;

    localparam int N     = 4;
    localparam int CW    = 32;
    localparam int RW    = 4;
    localparam int INF   = 1 << 30;
    localparam int NCASE = 40;

    typedef struct { int t; int ch; bit p; bit f; bit x; logic [31:0] v; } ev_s;
    typedef struct {
        int k_rise; tb_status_e st; bit pass; bit tmo;
        int fch; logic [31:0] fval; int cyc; logic [N-1:0] fin;
    } exp_s;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req = 1'b0;
    logic [CW-1:0]   max_c = '0;
    logic [N-1:0]    tp = '0, tf = '0, xv = '0;
    logic [N*32-1:0] xval = '0;

    logic          crst[2];
    tb_status_e    st[2];
    logic [CW-1:0] cyc[2];
    logic [N-1:0]  fin[2];
    logic          done[2], pas[2], tmo[2];
    logic [1:0]    fch[2];
    logic [31:0]   fval[2];

    ev_s  evq[$];
    exp_s sbq[2][$];
    int   checks = 0, failures = 0;
    int   cur_k = -1;
    bit   dprev[2];

    always #5 clk = ~clk;

    tb_test_status_ctrl #(.NUM_CHANNELS(N), .CYCLE_W(CW), .RESET_WAIT_CYCLES(RW), .FAIL_FAST(0)) u_slow (
        .clk_i(clk), .rst_ni(rst_n), .max_cycles_i(max_c), .reset_req_i(req),
        .tests_passed_i(tp), .tests_failed_i(tf), .exit_valid_i(xv), .exit_value_i(xval),
        .core_rst_no(crst[0]), .state_o(st[0]), .cycle_cnt_o(cyc[0]), .finished_o(fin[0]),
        .done_o(done[0]), .pass_o(pas[0]), .timeout_o(tmo[0]), .fail_chan_o(fch[0]),
        .fail_value_o(fval[0]));

    tb_test_status_ctrl #(.NUM_CHANNELS(N), .CYCLE_W(CW), .RESET_WAIT_CYCLES(RW), .FAIL_FAST(1)) u_fast (
        .clk_i(clk), .rst_ni(rst_n), .max_cycles_i(max_c), .reset_req_i(req),
        .tests_passed_i(tp), .tests_failed_i(tf), .exit_valid_i(xv), .exit_value_i(xval),
        .core_rst_no(crst[1]), .state_o(st[1]), .cycle_cnt_o(cyc[1]), .finished_o(fin[1]),
        .done_o(done[1]), .pass_o(pas[1]), .timeout_o(tmo[1]), .fail_chan_o(fch[1]),
        .fail_value_o(fval[1]));

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0d required=%0d", nm, d, act, exp);
        end
    endtask

    // Run-level model: first report per channel, earliest failure, time all
    // channels are done, watchdog time; the earliest applicable event wins.
    function automatic void model(input int ff, input int mx, input int r, input int rk,
                                  output bit has, output exp_s e);
        int fc[N]; bit fl[N]; logic [31:0] vl[N];
        int ft, fchan, afin, tend;
        bit anyfail;
        for (int c = 0; c < N; c++) begin fc[c] = INF; fl[c] = 0; vl[c] = '0; end
        foreach (evq[i]) begin
            if (evq[i].t < fc[evq[i].ch]) begin
                fc[evq[i].ch] = evq[i].t;
                fl[evq[i].ch] = evq[i].f || (evq[i].x && evq[i].v != 0);
                vl[evq[i].ch] = evq[i].f ? 32'd1 : evq[i].v;
            end
        end
        ft = INF; fchan = 0; afin = 0; anyfail = 0;
        for (int c = 0; c < N; c++) begin
            if (fl[c] && fc[c] < ft) begin ft = fc[c]; fchan = c; end
            if (fc[c] > afin) afin = fc[c];
            anyfail |= fl[c];
        end
        tend = (mx != 0) ? mx : INF;
        if (afin < tend) tend = afin;
        if (ff != 0 && ft < tend) tend = ft;
        has = (tend < INF) && ((rk == 0) || (rk == 1 && tend < r) || (rk == 2 && tend < r - 1));
        e.k_rise = tend + 1;
        e.cyc    = tend;
        if (ff != 0 && ft == tend)  e.st = ST_FAIL;
        else if (afin == tend)      e.st = anyfail ? ST_FAIL : ST_PASS;
        else                        e.st = ST_TIMEOUT;
        e.pass = (e.st == ST_PASS);
        e.tmo  = (e.st == ST_TIMEOUT);
        e.fch  = (ft <= tend) ? fchan : 0;
        e.fval = (ft <= tend) ? vl[fchan] : 32'd0;
        for (int c = 0; c < N; c++) e.fin[c] = (fc[c] <= tend);
    endfunction

    // Monitor: every rising done_o consumes one predicted verdict.
    always @(negedge clk) begin
        exp_s e;
        for (int d = 0; d < 2; d++) begin
            if (done[d] && !dprev[d]) begin
                if (sbq[d].size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done dut%0d actual=1 required=0 k=%0d", d, cur_k);
                end else begin
                    e = sbq[d].pop_front();
                    chk("done_cycle", d, 64'(cur_k), 64'(e.k_rise));
                    chk("verdict_state", d, 64'(st[d]), 64'(e.st));
                    chk("pass", d, 64'(pas[d]), 64'(e.pass));
                    chk("timeout", d, 64'(tmo[d]), 64'(e.tmo));
                    chk("fail_chan", d, 64'(fch[d]), 64'(e.fch));
                    chk("fail_value", d, 64'(fval[d]), 64'(e.fval));
                    chk("cycle_frozen", d, 64'(cyc[d]), 64'(e.cyc));
                    chk("finished", d, 64'(fin[d]), 64'(e.fin));
                end
            end
            dprev[d] = done[d];
        end
    end

    task automatic chk_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_state"}, d, 64'(st[d]), 64'(ST_RESET));
            chk({tag, "_core_rst"}, d, 64'(crst[d]), 64'd0);
            chk({tag, "_cycle"}, d, 64'(cyc[d]), 64'd0);
            chk({tag, "_finished"}, d, 64'(fin[d]), 64'd0);
            chk({tag, "_flags"}, d, 64'({done[d], pas[d], tmo[d]}), 64'd0);
            chk({tag, "_fail"}, d, 64'({fch[d], fval[d]}), 64'd0);
        end
    endtask

    task automatic idle_inputs();
        tp = '0; tf = '0; xv = '0; xval = '0;
    endtask

    task automatic drive(input int k);
        idle_inputs();
        foreach (evq[i]) begin
            if (evq[i].t == k) begin
                tp[evq[i].ch] = evq[i].p;
                tf[evq[i].ch] = evq[i].f;
                xv[evq[i].ch] = evq[i].x;
                xval[32*evq[i].ch +: 32] = evq[i].v;
            end
        end
    endtask

    // 1: reset_req pulse, 2: rst_n pulse. Leaves both DUTs at hold count 0.
    task automatic restart(input int kind);
        if (kind == 1) begin
            req = 1'b1;
            @(posedge clk); #1;
            req = 1'b0;
            idle_inputs();
            for (int d = 0; d < 2; d++) begin
                chk("req_state", d, 64'(st[d]), 64'(ST_RESET));
                chk("req_core_rst", d, 64'(crst[d]), 64'd0);
                chk("req_finished", d, 64'(fin[d]), 64'd0);
                chk("req_done", d, 64'(done[d]), 64'd0);
                chk("req_fail", d, 64'({fch[d], fval[d]}), 64'd0);
            end
        end else begin
            idle_inputs();
            rst_n = 1'b0;
            #1;
            chk_reset_vals("async_rst");
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    task automatic bring_up();
        int n = 0;
        while (crst[0] !== 1'b1 && n < 4 * RW) begin @(posedge clk); #1; n++; end
        chk("rst_latency", 0, 64'(n), 64'(RW));
        for (int d = 0; d < 2; d++) begin
            chk("core_rst_rise", d, 64'(crst[d]), 64'd1);
            chk("run_state", d, 64'(st[d]), 64'(ST_RUN));
            chk("cycle_start", d, 64'(cyc[d]), 64'd0);
        end
        cur_k = 0;
    endtask

    task automatic run_case(input int mx, input int r, input int rk);
        bit   has;
        exp_s e;
        int   tend[2];
        int   last_k = 0;
        foreach (evq[i]) if (evq[i].t > last_k) last_k = evq[i].t;
        for (int d = 0; d < 2; d++) begin
            model(d, mx, r, rk, has, e);
            tend[d] = e.cyc;
            if (has) sbq[d].push_back(e);
            if (rk == 0 && e.cyc > last_k) last_k = e.cyc;
        end
        last_k = (rk != 0) ? r - 1 : last_k + 2;
        for (int k = 0; k <= last_k; k++) begin
            cur_k = k;
            drive(k);
            @(posedge clk); #1;
        end
        idle_inputs();
        if (rk != 0) begin
            cur_k = r;
            if (rk == 1) drive(r);
            restart(rk);
        end else begin
            for (int d = 0; d < 2; d++) begin
                chk("done_sticky", d, 64'(done[d]), 64'd1);
                chk("cycle_held", d, 64'(cyc[d]), 64'(tend[d]));
            end
        end
    endtask

    task automatic add_ev(input int t, input int ch, input bit p, input bit f, input bit x,
                          input logic [31:0] v);
        ev_s e;
        e.t = t; e.ch = ch; e.p = p; e.f = f; e.x = x; e.v = v;
        evq.push_back(e);
    endtask

    task automatic directed(input int n, output int mx, output int r, output int rk);
        evq.delete(); mx = 0; r = 0; rk = 0;
        case (n)
            0: begin add_ev(20,0,1,0,0,0); add_ev(5,1,1,0,0,0); add_ev(12,2,1,0,0,0); add_ev(20,3,1,0,0,0); end
            1: begin add_ev(8,0,0,0,1,0); add_ev(15,1,0,0,1,0); add_ev(22,2,0,0,1,5); add_ev(30,3,0,0,1,0); end
            2: begin for (int c = 0; c < 3; c++) add_ev(3,c,1,0,0,0); add_ev(10,3,0,1,0,0); end
            3: mx = 100;
            4: begin mx = 40; for (int c = 0; c < 3; c++) add_ev(10,c,1,0,0,0); add_ev(40,3,1,0,0,0); end
            5: begin add_ev(7,1,1,1,0,0); add_ev(4,0,1,0,0,0); add_ev(4,2,1,0,0,0); add_ev(4,3,1,0,0,0); end
            6: begin add_ev(9,0,0,0,1,7); add_ev(9,1,0,1,0,0); add_ev(20,2,1,0,0,0); add_ev(20,3,1,0,0,0); end
            7: begin add_ev(10,0,1,0,0,0); add_ev(30,2,0,1,0,0); r = 50; rk = 1; end
            default: begin add_ev(5,0,1,0,0,0); r = 25; rk = 2; end
        endcase
    endtask

    task automatic gen_random(output int mx, output int r, output int rk);
        bit         all = 1;
        logic [2:0] fl3;
        int         t, sel;
        evq.delete();
        mx = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(5, 60));
        for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 99) < 85) begin
                t   = int'($urandom_range(0, 60));
                fl3 = 3'($urandom_range(1, 7));
                add_ev(t, c, fl3[2], fl3[1], fl3[0], ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom);
                if ($urandom_range(0, 3) == 0) begin
                    fl3 = 3'($urandom_range(1, 7));
                    add_ev(t + int'($urandom_range(1, 20)), c, fl3[2], fl3[1], fl3[0], $urandom);
                end
            end else begin
                all = 0;
            end
        end
        if (mx == 0 && !all) mx = 70;
        sel = int'($urandom_range(0, 9));
        rk  = (sel < 2) ? 1 : (sel == 2) ? 2 : 0;
        r   = int'($urandom_range(0, 60));
    endtask

    initial begin
        int mx, r, rk;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst_n = 1'b1;
        for (int n = 0; n < NCASE; n++) begin
            if (n < 9) directed(n, mx, r, rk);
            else       gen_random(mx, r, rk);
            max_c = CW'(mx);
            bring_up();
            run_case(mx, r, rk);
            if (rk == 0) restart((n % 2) + 1);
        end
        for (int d = 0; d < 2; d++) chk("verdicts_seen", d, 64'(sbq[d].size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
